// File: rtl/sal_ram_pkg.sv
// Shared constants for the sal_* RAM primitives: collision policy names and
// Vivado ram_style attribute values.
package sal_ram_pkg;

   // Same-address write/read policy names accepted by RW_SYNC.
   localparam string RwRdFirst = "RD_FIRST";
   localparam string RwWrFirst = "WR_FIRST";

   // ram_style attribute values used when VIVADO=1.
   localparam string RamStyleBlock = "block";
   localparam string RamStyleDist  = "distributed";

endpackage

// File: rtl/sal_sdp_ram.sv
// Simple dual-port RAM: port A write-only, port B read-only, single clock.
// The read port is either registered (1-cycle latency) or combinational.
// The same-address write/read policy is selected by RW_SYNC.
// The optional macro SAL_SDP_RAM_COLLISION_CHECK_EN compiles in a simulation-only
// same-address collision warning.
module sal_sdp_ram
   import sal_ram_pkg::*;
#(
   parameter int unsigned DEPTH_LG2    = 8,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned RDATA_FF_OUT = 1,
   parameter string       RW_SYNC      = "RD_FIRST",
   parameter int unsigned VIVADO       = 1,
   parameter int unsigned BRAM_VERSION = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_a,
   input  logic                  we_a,
   input  logic [DEPTH_LG2-1:0]  addr_a,
   input  logic [DATA_WIDTH-1:0] di_a,
   input  logic                  en_b,
   input  logic [DEPTH_LG2-1:0]  addr_b,
   output logic [DATA_WIDTH-1:0] do_b
);

   localparam int unsigned Depth = 2 ** DEPTH_LG2;

   // Writes are blocked while reset is held. The array itself is never reset.
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] rd_word;

   assign wr_en = rst_n & en_a & we_a;

   // Parameter legality
   if ((RW_SYNC != RwRdFirst) && (RW_SYNC != RwWrFirst)) begin : g_bad_rw_sync
      $fatal(1, "sal_sdp_ram: RW_SYNC must be \"RD_FIRST\" or \"WR_FIRST\"");
   end
   if (RDATA_FF_OUT > 1) begin : g_bad_ff_out
      $fatal(1, "sal_sdp_ram: RDATA_FF_OUT must be 0 or 1");
   end

   // Storage: the array is declared per branch so the ram_style attribute can be a literal.
   if ((VIVADO != 0) && (BRAM_VERSION != 0)) begin : g_mem_block
      (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [Depth];
      // Port A write
      always_ff @(posedge clk) begin
         if (wr_en) mem_q[addr_a] <= di_a;
      end
      assign rd_word = mem_q[addr_b];
   end else if (VIVADO != 0) begin : g_mem_dist
      (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_q [Depth];
      // Port A write
      always_ff @(posedge clk) begin
         if (wr_en) mem_q[addr_a] <= di_a;
      end
      assign rd_word = mem_q[addr_b];
   end else begin : g_mem_plain
      logic [DATA_WIDTH-1:0] mem_q [Depth];
      // Port A write
      always_ff @(posedge clk) begin
         if (wr_en) mem_q[addr_a] <= di_a;
      end
      assign rd_word = mem_q[addr_b];
   end

   // Read port
   if (RDATA_FF_OUT != 0) begin : g_rd_ff
      logic                  rd_en;
      logic                  coll;
      logic [DATA_WIDTH-1:0] do_b_d;
      logic [DATA_WIDTH-1:0] do_b_q;

      assign rd_en = rst_n & en_b;
      assign coll  = wr_en & (addr_a == addr_b);

      // Next read word: rd_word holds the pre-write contents, so RD_FIRST needs no
      // special case. WR_FIRST bypasses the incoming write data.
      always_comb begin
         do_b_d = do_b_q;
         if (rd_en) begin
            if ((RW_SYNC == RwWrFirst) && coll) do_b_d = di_a;
            else                                 do_b_d = rd_word;
         end
      end

      // Output register, cleared asynchronously. It holds its value while en_b=0.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) do_b_q <= '0;
         else        do_b_q <= do_b_d;
      end

      assign do_b = do_b_q;
   end else begin : g_rd_comb
      assign do_b = rd_word;
   end

`ifdef SAL_SDP_RAM_COLLISION_CHECK_EN
   // Simulation-only warning on same-address write/read
   always @(posedge clk) begin
      if (rst_n && en_a && we_a && en_b && (addr_a == addr_b)) begin
         $display("%0t sal_sdp_ram: warning: write/read collision at addr 0x%0h (policy %s)",
                  $time, addr_a, RW_SYNC);
      end
   end
`endif

endmodule

// File: tb/tb_sal_sdp_ram.sv
// Directed bench for sal_sdp_ram: RD_FIRST and WR_FIRST registered instances plus a
// combinational-read instance, all sharing one set of stimulus.
module tb_sal_sdp_ram;

   localparam int unsigned Aw = 4;
   localparam int unsigned Dw = 32;

   logic          clk;
   logic          rst_n;
   logic          en_a;
   logic          we_a;
   logic [Aw-1:0] addr_a;
   logic [Dw-1:0] di_a;
   logic          en_b;
   logic [Aw-1:0] addr_b;
   logic [Dw-1:0] do_rd;
   logic [Dw-1:0] do_wr;
   logic [Dw-1:0] do_cb;

   int n_cmp = 0;
   int n_err = 0;

   sal_sdp_ram #(
      .DEPTH_LG2(Aw), .DATA_WIDTH(Dw), .RDATA_FF_OUT(1), .RW_SYNC("RD_FIRST"),
      .VIVADO(1), .BRAM_VERSION(1)
   ) u_rd (
      .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
      .en_b(en_b), .addr_b(addr_b), .do_b(do_rd)
   );

   sal_sdp_ram #(
      .DEPTH_LG2(Aw), .DATA_WIDTH(Dw), .RDATA_FF_OUT(1), .RW_SYNC("WR_FIRST"),
      .VIVADO(1), .BRAM_VERSION(0)
   ) u_wr (
      .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
      .en_b(en_b), .addr_b(addr_b), .do_b(do_wr)
   );

   sal_sdp_ram #(
      .DEPTH_LG2(Aw), .DATA_WIDTH(Dw), .RDATA_FF_OUT(0), .RW_SYNC("RD_FIRST"),
      .VIVADO(0), .BRAM_VERSION(0)
   ) u_cb (
      .clk(clk), .rst_n(rst_n), .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .di_a(di_a),
      .en_b(en_b), .addr_b(addr_b), .do_b(do_cb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [Dw-1:0] got, input logic [Dw-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [Aw-1:0] a, input logic [Dw-1:0] d);
      en_a = 1'b1; we_a = 1'b1; addr_a = a; di_a = d;
   endtask

   task automatic idle_a();
      en_a = 1'b0; we_a = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; en_a = 1'b0; we_a = 1'b0; addr_a = '0; di_a = '0;
      en_b = 1'b0; addr_b = '0;
      cyc(); cyc();
      check_eq("reset_rd", do_rd, 32'h0);
      check_eq("reset_wr", do_wr, 32'h0);
      rst_n = 1'b1;

      // 1: write @3, read it back with one cycle of latency
      wr(4'd3, 32'hA5A5_0003);
      cyc();
      idle_a(); en_b = 1'b1; addr_b = 4'd3;
      #1 check_eq("t1_comb", do_cb, 32'hA5A5_0003);
      cyc();
      check_eq("t1_rd", do_rd, 32'hA5A5_0003);
      check_eq("t1_wr", do_wr, 32'hA5A5_0003);

      // 2/3: same-address collision
      wr(4'd5, 32'h11); en_b = 1'b0;
      cyc();
      wr(4'd5, 32'h22); en_b = 1'b1; addr_b = 4'd5;
      cyc();
      check_eq("t2_coll_rd_first", do_rd, 32'h11);
      check_eq("t3_coll_wr_first", do_wr, 32'h22);
      idle_a();
      cyc();
      check_eq("t2_reread_rd", do_rd, 32'h22);
      check_eq("t3_reread_wr", do_wr, 32'h22);

      // 4: en_b=0 holds the last read word
      addr_b = 4'd3;
      cyc();
      check_eq("t4_read", do_rd, 32'hA5A5_0003);
      en_b = 1'b0; addr_b = 4'd7;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check_eq("t4_hold_rd", do_rd, 32'hA5A5_0003);
         check_eq("t4_hold_wr", do_wr, 32'hA5A5_0003);
      end

      // 5: asynchronous reset between edges; writes/reads blocked while held
      #3 rst_n = 1'b0;
      #1;
      check_eq("t5_async_rd", do_rd, 32'h0);
      check_eq("t5_async_wr", do_wr, 32'h0);
      wr(4'd3, 32'h0BAD_0BAD); en_b = 1'b1; addr_b = 4'd3;
      cyc();
      check_eq("t5_blocked_rd", do_rd, 32'h0);
      rst_n = 1'b1; idle_a();
      cyc();
      check_eq("t5_after_rd", do_rd, 32'hA5A5_0003);
      check_eq("t5_after_wr", do_wr, 32'hA5A5_0003);

      // 6: fill all addresses, read back in reverse
      en_b = 1'b0;
      for (int i = 0; i < 16; i++) begin
         wr(4'(i), 32'(i * 32'h0101));
         cyc();
      end
      idle_a(); en_b = 1'b1;
      for (int i = 15; i >= 0; i--) begin
         addr_b = 4'(i);
         #1 check_eq("t6_comb", do_cb, 32'(i * 32'h0101));
         cyc();
         check_eq("t6_rd", do_rd, 32'(i * 32'h0101));
      end
      en_a = 1'b1; we_a = 1'b0; addr_a = 4'd0; di_a = 32'hFFFF_FFFF; en_b = 1'b0;
      cyc();
      idle_a(); en_b = 1'b1; addr_b = 4'd0;
      cyc();
      check_eq("t6_we0_no_write", do_rd, 32'h0000);

      // Independent write and read at different addresses in the same cycle
      wr(4'd1, 32'h77); addr_b = 4'd2;
      cyc();
      check_eq("indep_read", do_rd, 32'h0202);
      check_eq("indep_read_wr", do_wr, 32'h0202);
      idle_a(); addr_b = 4'd1;
      cyc();
      check_eq("indep_write", do_rd, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
